exec_sequencer: RTL and testbench
=================================

# exec_sequencer

Run/step sequencer for the i281 multicycle core: decides when the control FSM and datapath may advance by driving a single clock-enable, `cpu_en`. Supports free-run, single-instruction step, stop-at-instruction-boundary and an optional PC breakpoint. Keeps saturating cycle and instruction counters for the board display. Sits between the debounced board buttons/switches and the control FSM's enable input.

## Interface
- `PC_W`, 6: program-counter width (64-word instruction memory).
- `CNT_W`, 16: width of both performance counters.
- Ports:
  - `clock`  in  1  system clock; single clock domain, all logic on rising edge.
  - `reset`  in  1  synchronous, active-high; whole block returns to reset values.
  - `run`  in  1  level switch. Rising edge starts free-run; falling edge requests stop.
  - `step`  in  1  one-cycle pulse from the debounced button; requests one instruction.
  - `halt_req`  in  1  one-cycle pulse; requests stop at the next instruction boundary.
  - `instr_done`  in  1  from control FSM; high in the last microstep of an instruction. Ignored when `cpu_en`=0.
  - `pc_next`  in  PC_W  address of the next instruction to fetch; valid when `instr_done`=1.
  - `bp_valid`  in  1  breakpoint armed.
  - `bp_addr`  in  PC_W  breakpoint address.
  - `clear_counts`  in  1  synchronous clear of both counters.
  - `cpu_en`  out  1  registered enable to control FSM and datapath registers.
  - `busy`  out  1  state != IDLE.
  - `bp_hit`  out  1  sticky; set when a breakpoint stop occurs.
  - `seq_state`  out  2  current state encoding, for debug LEDs.
  - `cycle_count`  out  CNT_W  enabled cycles, saturating.
  - `instr_count`  out  CNT_W  completed instructions, saturating.

## Operation
- States: IDLE=0, RUN=1, STEP=2, STOPPING=3. `cpu_en`=1 in every state except IDLE.
- Internal registered `run_q` provides edge detection; `run_rise = run & ~run_q`, `run_fall = ~run & run_q`.
- Accepted instruction boundary: `done_ok = instr_done & cpu_en`.
- IDLE:
  - `run_rise` → RUN; clears `bp_hit`.
  - Otherwise `step` → STEP; clears `bp_hit`.
  - `run_rise` wins over a simultaneous `step`.
  - `halt_req` has no effect.
- RUN:
  - `done_ok` with breakpoint hit (`bp_valid` and `pc_next == bp_addr`) → IDLE and set `bp_hit`.
  - Otherwise `run_fall` or `halt_req` → STOPPING. If `done_ok` is high in that same cycle → IDLE directly.
  - `step` is ignored.
- STEP:
  - `done_ok` → IDLE.
  - `run_rise` → RUN, and the instruction in flight continues without a gap.
  - `halt_req` is ignored, since the step already stops at the boundary.
- STOPPING:
  - `done_ok` → IDLE.
  - `run_rise` → RUN (stop cancelled).
- The breakpoint is checked only at instruction completion, against the next PC. Resuming from a breakpoint therefore executes the instruction at `bp_addr` before the next check.
- An instruction is never cut mid-microstep. `cpu_en` only falls after `done_ok`.
- Counters:
  - `cycle_count` += 1 each cycle `cpu_en`=1.
  - `instr_count` += 1 on `done_ok`.
  - Both hold at all-ones; no wrap.
  - `clear_counts` zeroes both and has priority over increment in the same cycle.

## Timing
- Reset values: state=IDLE, `run_q`=0, `cpu_en`=0, `busy`=0, `bp_hit`=0, `seq_state`=0, both counts=0.
- If `run` is already high at reset release, a `run_rise` is seen in the first cycle after reset.
- Start latency: a `run_rise`/`step` in cycle N gives `cpu_en`=1 from cycle N+1.
- Stop latency: `done_ok` in cycle N gives `cpu_en`=0 from cycle N+1. The microstep in cycle N completes.
- `cpu_en`, `busy` and `seq_state` come straight from the state register; there is no combinational input-to-output path.
- Reset mid-instruction: `cpu_en` drops the next cycle. Recovering the control FSM is the job of the shared `reset`.

## Configuration
- `EXEC_SEQ_BREAKPOINT_EN` defined:
  - Breakpoint compare is built.
  - `bp_hit` behaves as specified.
- `EXEC_SEQ_BREAKPOINT_EN` undefined:
  - Compare logic is removed.
  - `bp_valid` and `bp_addr` are ignored.
  - `bp_hit` is tied to 0.
  - All other behaviour is identical.

## Structure
- Shared package `i281_seq_pkg`: state enum (IDLE/RUN/STEP/STOPPING with fixed encodings 0–3), plus default constants `PC_W`=6 and `CNT_W`=16.
- One sub-module, `sat_counter`: parameterised width, with `clr` and `inc` inputs, clear priority and hold at max. Instantiated twice.

## Test plan
- Reset with `run`=0, then a `step` pulse against an FSM model with a 3-cycle instruction → `cpu_en` high exactly 3 cycles starting the cycle after `step`; `instr_count`=1, `cycle_count`=3, final state IDLE.
- `run` rises, 5 instructions complete, `run` falls mid-instruction → state is STOPPING until that instruction's `instr_done`, then `cpu_en`=0 the next cycle; `instr_count`=6.
- Breakpoint at 0x0A with `run` high, program reaches `pc_next`=0x0A → stop, `bp_hit`=1. Toggle `run` → `bp_hit` clears and execution continues past 0x0A.
- Simultaneous checks:
  - `run_rise` and `step` in IDLE → RUN.
  - `halt_req` and `done_ok` in RUN → IDLE directly.
  - `clear_counts` with an increment → counters read 0.
- Counters preloaded via forced 0xFFFE, run 4 cycles → `cycle_count` holds 0xFFFF.
- `reset` asserted during RUN → next cycle all outputs at reset values. With the macro undefined, breakpoint address matched → no stop, `bp_hit`=0.

Source files
------------

// File: rtl/i281_seq_pkg.sv
// Shared types and default sizes for the i281 run/step sequencer.
package i281_seq_pkg;

    localparam int PC_W  = 6;
    localparam int CNT_W = 16;

    // Encodings are fixed because they drive the board debug LEDs directly.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_STEP     = 2'd2,
        ST_STOPPING = 2'd3
    } seq_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment and the count holds at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q, count_d;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        count_d = count_q;
        if (clr)
            count_d = '0;
        else if (inc && (count_q != '1))
            count_d = count_q + W'(1);
    end

    // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
    always_ff @(posedge clock) begin
        if (reset)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/exec_sequencer.sv
// Run/step sequencer driving the i281 control FSM clock-enable, with saturating perf counters.
// Define EXEC_SEQ_BREAKPOINT_EN to build the PC breakpoint compare; otherwise bp_hit is tied to 0.
module exec_sequencer #(
    parameter int PC_W  = i281_seq_pkg::PC_W,
    parameter int CNT_W = i281_seq_pkg::CNT_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             run,
    input  logic             step,
    input  logic             halt_req,
    input  logic             instr_done,
    input  logic [PC_W-1:0]  pc_next,
    input  logic             bp_valid,
    input  logic [PC_W-1:0]  bp_addr,
    input  logic             clear_counts,
    output logic             cpu_en,
    output logic             busy,
    output logic             bp_hit,
    output logic [1:0]       seq_state,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instr_count
);

    import i281_seq_pkg::*;

    seq_state_e state_q, state_d;
    logic       run_q;
    logic       run_rise, run_fall, done_ok;
    logic       bp_match, bp_set, bp_clr;

    assign run_rise = run & ~run_q;
    assign run_fall = ~run & run_q;
    assign done_ok  = instr_done & cpu_en;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= run;
        end
    end

    always_comb begin
        state_d = state_q;
        bp_set  = 1'b0;
        bp_clr  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (run_rise) begin
                    state_d = ST_RUN;
                    bp_clr  = 1'b1;
                end else if (step) begin
                    state_d = ST_STEP;
                    bp_clr  = 1'b1;
                end
            end
            ST_RUN: begin
                if (done_ok && bp_match) begin
                    state_d = ST_IDLE;
                    bp_set  = 1'b1;
                end else if (run_fall || halt_req) begin
                    // A stop request landing on a boundary needs no STOPPING detour.
                    state_d = done_ok ? ST_IDLE : ST_STOPPING;
                end
            end
            ST_STEP, ST_STOPPING: begin
                if (done_ok)
                    state_d = ST_IDLE;
                else if (run_rise)
                    state_d = ST_RUN;
            end
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef EXEC_SEQ_BREAKPOINT_EN
    logic bp_hit_q;

    // Compared against the next PC, so resuming executes the instruction at bp_addr first.
    assign bp_match = bp_valid && (pc_next == bp_addr);

    always_ff @(posedge clock) begin
        if (reset)
            bp_hit_q <= 1'b0;
        else if (bp_set)
            bp_hit_q <= 1'b1;
        else if (bp_clr)
            bp_hit_q <= 1'b0;
    end

    assign bp_hit = bp_hit_q;
`else
    logic unused_bp;

    assign bp_match  = 1'b0;
    assign bp_hit    = 1'b0;
    assign unused_bp = ^{bp_valid, bp_addr, pc_next, bp_set, bp_clr};
`endif

    assign cpu_en    = (state_q != ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign seq_state = state_q;

    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clock (clock),
        .reset (reset),
        .clr   (clear_counts),
        .inc   (cpu_en),
        .count (cycle_count)
    );

    sat_counter #(.W(CNT_W)) u_instr_cnt (
        .clock (clock),
        .reset (reset),
        .clr   (clear_counts),
        .inc   (done_ok),
        .count (instr_count)
    );

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed bench for exec_sequencer: vector table for single-cycle corners, hand sequences with a 3-cycle FSM model.
module tb_exec_sequencer;

    logic        clock = 1'b0;
    logic        reset, run, step, halt_req, clear_counts;
    logic        bp_valid;
    logic [5:0]  bp_addr;
    logic        instr_done;
    logic [5:0]  pc_next;

    logic        use_model;
    logic        man_done;
    logic [5:0]  man_pc;
    logic [1:0]  ustep;
    logic [5:0]  mpc;

    logic        cpu_en, busy, bp_hit;
    logic [1:0]  seq_state;
    logic [15:0] cycle_count, instr_count;

    logic        sm_cpu_en, sm_busy, sm_bp_hit;
    logic [1:0]  sm_seq_state;
    logic [2:0]  sm_cycle_count, sm_instr_count;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clock = ~clock;

    // Control-FSM model: every instruction takes three enabled cycles, PC increments by one.
    always @(posedge clock) begin
        if (reset) begin
            ustep <= 2'd0;
            mpc   <= 6'd0;
        end else if (use_model && cpu_en) begin
            if (ustep == 2'd2) begin
                ustep <= 2'd0;
                mpc   <= mpc + 6'd1;
            end else begin
                ustep <= ustep + 2'd1;
            end
        end
    end

    assign instr_done = use_model ? (ustep == 2'd2) : man_done;
    assign pc_next    = use_model ? (mpc + 6'd1)    : man_pc;

    exec_sequencer #(.PC_W(6), .CNT_W(16)) dut (
        .clock        (clock),
        .reset        (reset),
        .run          (run),
        .step         (step),
        .halt_req     (halt_req),
        .instr_done   (instr_done),
        .pc_next      (pc_next),
        .bp_valid     (bp_valid),
        .bp_addr      (bp_addr),
        .clear_counts (clear_counts),
        .cpu_en       (cpu_en),
        .busy         (busy),
        .bp_hit       (bp_hit),
        .seq_state    (seq_state),
        .cycle_count  (cycle_count),
        .instr_count  (instr_count)
    );

    // Narrow-counter copy, used to observe saturation within a few cycles.
    exec_sequencer #(.PC_W(6), .CNT_W(3)) dut_small (
        .clock        (clock),
        .reset        (reset),
        .run          (run),
        .step         (step),
        .halt_req     (halt_req),
        .instr_done   (instr_done),
        .pc_next      (pc_next),
        .bp_valid     (bp_valid),
        .bp_addr      (bp_addr),
        .clear_counts (clear_counts),
        .cpu_en       (sm_cpu_en),
        .busy         (sm_busy),
        .bp_hit       (sm_bp_hit),
        .seq_state    (sm_seq_state),
        .cycle_count  (sm_cycle_count),
        .instr_count  (sm_instr_count)
    );

    typedef struct {
        logic       rst, run, step, halt, done, clr;
        logic [1:0] st;
        int         cc, ic;
    } vec_t;

    vec_t vecs[24];

    function automatic vec_t mk(input logic rst, input logic r, input logic s, input logic h,
                                input logic d, input logic c, input logic [1:0] st,
                                input int cc, input int ic);
        vec_t v;
        v.rst = rst; v.run = r; v.step = s; v.halt = h; v.done = d; v.clr = c;
        v.st = st; v.cc = cc; v.ic = ic;
        return v;
    endfunction

    task automatic check(input string name, input longint actual, input longint expected);
        n_vec++;
        if (actual !== expected) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_state(input string tag, input logic [1:0] st);
        check({tag, ".seq_state"}, seq_state, st);
        check({tag, ".cpu_en"}, cpu_en, st != 2'd0);
        check({tag, ".busy"}, busy, st != 2'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //             rst run stp hlt don clr st   cc  ic
        vecs[0]  = mk(1, 0, 0, 0, 0, 0, 2'd0, 0,  0);
        vecs[1]  = mk(0, 1, 1, 0, 0, 0, 2'd1, 0,  0);  // run_rise beats step
        vecs[2]  = mk(0, 1, 0, 0, 0, 0, 2'd1, 1,  0);
        vecs[3]  = mk(0, 1, 0, 0, 1, 0, 2'd1, 2,  1);
        vecs[4]  = mk(0, 1, 0, 1, 1, 0, 2'd0, 3,  2);  // halt + done -> IDLE directly
        vecs[5]  = mk(0, 1, 0, 0, 0, 0, 2'd0, 3,  2);
        vecs[6]  = mk(0, 1, 0, 1, 0, 0, 2'd0, 3,  2);  // halt in IDLE ignored
        vecs[7]  = mk(0, 0, 0, 0, 0, 0, 2'd0, 3,  2);
        vecs[8]  = mk(0, 0, 1, 0, 0, 0, 2'd2, 3,  2);
        vecs[9]  = mk(0, 0, 0, 1, 0, 0, 2'd2, 4,  2);  // halt in STEP ignored
        vecs[10] = mk(0, 1, 0, 0, 0, 0, 2'd1, 5,  2);  // STEP -> RUN
        vecs[11] = mk(0, 0, 0, 0, 0, 0, 2'd3, 6,  2);
        vecs[12] = mk(0, 0, 0, 0, 0, 0, 2'd3, 7,  2);
        vecs[13] = mk(0, 1, 0, 0, 0, 0, 2'd1, 8,  2);  // stop cancelled
        vecs[14] = mk(0, 0, 0, 0, 0, 0, 2'd3, 9,  2);
        vecs[15] = mk(0, 0, 0, 0, 1, 0, 2'd0, 10, 3);
        vecs[16] = mk(0, 0, 0, 0, 1, 0, 2'd0, 10, 3);  // done ignored while disabled
        vecs[17] = mk(0, 0, 1, 0, 0, 1, 2'd2, 0,  0);
        vecs[18] = mk(0, 0, 0, 0, 1, 1, 2'd0, 0,  0);  // clear beats increments
        vecs[19] = mk(0, 1, 0, 0, 0, 0, 2'd1, 0,  0);
        vecs[20] = mk(1, 1, 0, 0, 0, 0, 2'd0, 0,  0);  // reset during RUN
        vecs[21] = mk(0, 1, 0, 0, 0, 0, 2'd1, 0,  0);  // run high at release -> rise
        vecs[22] = mk(0, 0, 0, 0, 0, 0, 2'd3, 1,  0);
        vecs[23] = mk(0, 0, 0, 0, 1, 0, 2'd0, 2,  1);

        reset = 1'b1; run = 1'b0; step = 1'b0; halt_req = 1'b0; clear_counts = 1'b0;
        bp_valid = 1'b0; bp_addr = 6'd0;
        use_model = 1'b0; man_done = 1'b0; man_pc = 6'd0;

        for (int i = 0; i < 24; i++) begin
            reset = vecs[i].rst; run = vecs[i].run; step = vecs[i].step;
            halt_req = vecs[i].halt; man_done = vecs[i].done; clear_counts = vecs[i].clr;
            tick();
            check_state($sformatf("vec%0d", i), vecs[i].st);
            check($sformatf("vec%0d.bp_hit", i), bp_hit, 0);
            check($sformatf("vec%0d.cycle_count", i), cycle_count, vecs[i].cc);
            check($sformatf("vec%0d.instr_count", i), instr_count, vecs[i].ic);
        end
        reset = 1'b0; run = 1'b0; step = 1'b0; halt_req = 1'b0; man_done = 1'b0; clear_counts = 1'b0;

        // Single step through one 3-cycle instruction.
        use_model = 1'b1;
        reset = 1'b1; tick(); reset = 1'b0;
        step = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (k == 0) step = 1'b0;
            check($sformatf("stepA.cpu_en[%0d]", k), cpu_en, k < 3);
        end
        check("stepA.instr_count", instr_count, 1);
        check("stepA.cycle_count", cycle_count, 3);
        check_state("stepA.end", 2'd0);

        // Free-run 5 instructions, then drop run mid-instruction.
        reset = 1'b1; tick(); reset = 1'b0;
        run = 1'b1;
        for (int t = 0; t < 100 && instr_count != 16'd5; t++) tick();
        check("runB.reach5", instr_count, 5);
        tick();
        run = 1'b0;
        tick();
        check_state("runB.stopping", 2'd3);
        tick();
        check_state("runB.stopped", 2'd0);
        check("runB.instr_count", instr_count, 6);
        check("runB.cycle_count", cycle_count, 18);

        // Breakpoint at 0x0A while free-running.
        reset = 1'b1; tick(); reset = 1'b0;
        bp_valid = 1'b1; bp_addr = 6'h0A;
        run = 1'b1;
        tick();
`ifdef EXEC_SEQ_BREAKPOINT_EN
        for (int t = 0; t < 200 && cpu_en; t++) tick();
        check_state("bpC.stop", 2'd0);
        check("bpC.bp_hit_set", bp_hit, 1);
        check("bpC.instr_count", instr_count, 10);
        run = 1'b0; tick();
        run = 1'b1; tick();
        check_state("bpC.resume", 2'd1);
        check("bpC.bp_hit_clr", bp_hit, 0);
`endif
        for (int t = 0; t < 200 && instr_count != 16'd12; t++) tick();
        check("bpC.instr_past", instr_count, 12);
        check_state("bpC.running", 2'd1);
        check("bpC.bp_hit_end", bp_hit, 0);

        // Reset while running.
        run = 1'b0; bp_valid = 1'b0; use_model = 1'b0;
        reset = 1'b1; tick(); reset = 1'b0;
        check_state("rstD", 2'd0);
        check("rstD.bp_hit", bp_hit, 0);
        check("rstD.cycle_count", cycle_count, 0);
        check("rstD.instr_count", instr_count, 0);

        // Saturation on the 3-bit copy.
        run = 1'b1; tick();
        for (int k = 0; k < 10; k++) tick();
        check("satE.main_cc", cycle_count, 10);
        check("satE.small_cc", sm_cycle_count, 7);
        tick(); tick();
        check("satE.small_hold", sm_cycle_count, 7);
        check("satE.main_cc2", cycle_count, 12);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
